// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential multiply/divide pair: FSM states,
// operand widths and the last iteration index.
package seq_arith_pkg;

   localparam int DIV_W = 16;
   localparam int DVD_W = 32;
   localparam logic [3:0] LAST_ITER = 4'd15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      CALC  = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift the resulting quotient bit into Q.
module div_restore_step
   import seq_arith_pkg::*;
(
   input  logic [DIV_W-1:0] a_i,
   input  logic [DIV_W-1:0] q_i,
   input  logic [DIV_W-1:0] d_i,
   output logic [DIV_W:0]   a_o,
   output logic [DIV_W-1:0] q_o
);

   logic [DIV_W:0]   shifted;
   logic [DIV_W+1:0] diff;

   // A < D on entry, so the shifted value stays below 2*D and fits in 17 bits.
   assign shifted = {a_i, q_i[DIV_W-1]};
   assign diff    = {1'b0, shifted} - {2'b00, d_i};

   always_comb begin
      a_o = diff[DIV_W:0];
      q_o = {q_i[DIV_W-2:0], 1'b1};
      if (diff[DIV_W+1]) begin
         a_o = shifted;
         q_o = {q_i[DIV_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sequential_divider_32x16.sv
// 32/16 restoring divider producing one quotient bit per clock, with an upfront
// overflow / divide-by-zero check and a start/done handshake.
module sequential_divider_32x16
   import seq_arith_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             st,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             done,
   output logic             busy,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             ovf,
   output logic             dvz
);

   state_e           state_q, state_d;
   logic [DIV_W:0]   a_q, a_d;
   logic [DIV_W-1:0] q_q, q_d;
   logic [DIV_W-1:0] d_q, d_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             dvz_q, dvz_d;

   logic [DIV_W:0]   step_a;
   logic [DIV_W-1:0] step_q;

   div_restore_step u_step (
      .a_i (a_q[DIV_W-1:0]),
      .q_i (q_q),
      .d_i (d_q),
      .a_o (step_a),
      .q_o (step_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         dvz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         dvz_q   <= dvz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      dvz_d   = dvz_q;
      case (state_q)
         IDLE: begin
            if (st) begin
               a_d     = {1'b0, dividend[DVD_W-1:DIV_W]};
               q_d     = dividend[DIV_W-1:0];
               d_d     = divisor;
               ovf_d   = 1'b0;
               dvz_d   = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Upper dividend half >= divisor means the quotient needs more than 16 bits.
            if ((d_q == '0) || (a_q >= {1'b0, d_q})) begin
               ovf_d   = 1'b1;
               dvz_d   = (d_q == '0);
               q_d     = '1;
               a_d     = '0;
               state_d = DONE;
            end else begin
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d   = step_a;
            q_d   = step_q;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign done      = (state_q == DONE);
   assign busy      = (state_q == CHECK) || (state_q == CALC);
   assign quotient  = q_q;
   assign remainder = a_q[DIV_W-1:0];
   assign ovf       = ovf_q;
   assign dvz       = dvz_q;

endmodule

// File: tb/tb_sequential_divider_32x16.sv
// Directed-vector and round-trip bench for sequential_divider_32x16.
module tb_sequential_divider_32x16;

   logic        clk;
   logic        rst;
   logic        st;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        done;
   logic        busy;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        ovf;
   logic        dvz;

   int n_checks = 0;
   int n_fail   = 0;

   sequential_divider_32x16 dut (
      .clk       (clk),
      .rst       (rst),
      .st        (st),
      .dividend  (dividend),
      .divisor   (divisor),
      .done      (done),
      .busy      (busy),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dvz       (dvz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dvd;
      logic [15:0] dvs;
      logic [15:0] exp_q;
      logic [15:0] exp_r;
      logic        exp_ovf;
      logic        exp_dvz;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Start one division and wait for done; lat counts edges from the start edge.
   task automatic run_div(input logic [31:0] dvd, input logic [15:0] dvs, input bit tog,
                          output int lat, output int bcnt, output bit overlap, output bit pulse_ok);
      @(negedge clk);
      dividend = dvd;
      divisor  = dvs;
      st       = 1'b1;
      @(posedge clk);
      #1;
      st      = 1'b0;
      lat     = 0;
      bcnt    = 0;
      overlap = 1'b0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if (tog) begin
            st       = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = 16'($urandom);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      st = 1'b0;
      if (done && busy) overlap = 1'b1;
      if (!done) lat = -1;
      @(posedge clk);
      #1;
      pulse_ok = !done && !busy;
   endtask

   vec_t vecs[10];
   int   lat, bcnt;
   bit   overlap, pulse_ok;
   logic [15:0] a_r, b_r, r_r, held_q;
   logic [31:0] dvd_r;
   int   rt_fail;

   initial begin
      vecs[0] = '{32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17};
      vecs[1] = '{32'hFFFE_0001, 16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17};
      vecs[2] = '{32'd1234,      16'd0,      16'hFFFF,   16'h0000,   1'b1, 1'b1, 1};
      vecs[3] = '{32'h0001_0000, 16'h0001,   16'hFFFF,   16'h0000,   1'b1, 1'b0, 1};
      vecs[4] = '{32'd0,         16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 17};
      vecs[5] = '{32'h0000_FFFF, 16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17};
      vecs[6] = '{32'h1234_5678, 16'h1234,   16'hFFFF,   16'h0000,   1'b1, 1'b0, 1};
      vecs[7] = '{32'h1234_5678, 16'h1235,   16'hFFF6,   16'h0C8A,   1'b0, 1'b0, 17};
      vecs[8] = '{32'h0001_FFFF, 16'h0002,   16'hFFFF,   16'h0001,   1'b0, 1'b0, 17};
      vecs[9] = '{32'd7,         16'd10,     16'd0,      16'd7,      1'b0, 1'b0, 17};

      rst      = 1'b1;
      st       = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {done, busy, quotient, remainder, ovf, dvz}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].dvd, vecs[i].dvs, 1'b0, lat, bcnt, overlap, pulse_ok);
         check($sformatf("v%0d_quotient", i), quotient, vecs[i].exp_q);
         check($sformatf("v%0d_remainder", i), remainder, vecs[i].exp_r);
         check($sformatf("v%0d_ovf_dvz", i), {ovf, dvz}, {vecs[i].exp_ovf, vecs[i].exp_dvz});
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_handshake", i), {overlap, pulse_ok}, 2'b01);
      end

      // Results and flags hold through idle cycles until the next start.
      held_q = quotient;
      repeat (5) @(posedge clk);
      #1;
      check("hold_after_done", {quotient, remainder, ovf, dvz, busy, done}, {held_q, 16'h0007, 4'b0000});

      // Reset during CALC at cnt=8 (nine edges after the start edge).
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 16'd7;
      st       = 1'b1;
      @(posedge clk);
      #1;
      st = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      check("midop_busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("async_reset_outputs", {done, busy, quotient, remainder, ovf, dvz}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_div(32'd100, 16'd7, 1'b0, lat, bcnt, overlap, pulse_ok);
      check("post_reset_result", {quotient, remainder, ovf, dvz}, {16'd14, 16'd2, 2'b00});
      check("post_reset_latency", 64'(lat), 64'd17);

      // Round trip: (a*b + r) / b must give back a and r; odd cases wiggle st and operands mid-run.
      rt_fail = 0;
      for (int k = 0; k < 1500; k++) begin
         a_r   = 16'($urandom);
         b_r   = 16'($urandom_range(1, 65535));
         r_r   = 16'($urandom_range(0, int'(b_r) - 1));
         dvd_r = 32'(a_r) * 32'(b_r) + 32'(r_r);
         run_div(dvd_r, b_r, k[0], lat, bcnt, overlap, pulse_ok);
         n_checks++;
         if (quotient !== a_r || remainder !== r_r || ovf !== 1'b0 || lat != 17 || overlap || !pulse_ok) begin
            n_fail++;
            rt_fail++;
            $display("FAIL roundtrip_%0d: %0h/%0h got q=%0h r=%0h ovf=%0b lat=%0d expected q=%0h r=%0h lat=17",
                     k, dvd_r, b_r, quotient, remainder, ovf, lat, a_r, r_r);
         end
      end
      $display("roundtrip: 1500 cases, %0d bad", rt_fail);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
